// File: rtl/pipe_scoreboard.sv
// Purpose  : scoreboard of in-flight destination registers, with RAW stall and per-source forwarding selects.
// Latency  : stall/fwd_sel/pending are combinational from registered slots; an accepted issue is visible next cycle.
// Backpres : stall holds decode on an unresolvable hazard or downstream hold; hold freezes every slot.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   issue_valid_i            decode presents an instruction
//   issue_src_i              NUM_SRC source addresses, src k at [k*REG_AW +: REG_AW]
//   issue_src_used_i         per-source "operand is read" flag
//   issue_rd_i, issue_we_i   destination address / writes-destination flag
//   issue_is_load_i          result only available at the slot 1 output
//   hold_i                   downstream stall, freezes all slots
//   flush_i                  branch redirect: kills slot 0 and the current issue
//   stall_o, issue_accept_o  decode hold / instruction accepted this cycle
//   fwd_sel_o                per source: 0 = regfile, s+1 = forward from slot s
//   inflight_cnt_o           number of valid writing slots
//   pending_o                bit r set if any valid slot writes r
module pipe_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2,
    parameter int FWD_EN  = 1,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        issue_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0]   issue_src_i,
    input  logic [NUM_SRC-1:0]          issue_src_used_i,
    input  logic [REG_AW-1:0]           issue_rd_i,
    input  logic                        issue_we_i,
    input  logic                        issue_is_load_i,
    input  logic                        hold_i,
    input  logic                        flush_i,
    output logic                        stall_o,
    output logic                        issue_accept_o,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
    output logic [$clog2(DEPTH+1)-1:0]  inflight_cnt_o,
    output logic [2**REG_AW-1:0]        pending_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } slot_t;

    slot_t slot_q [DEPTH];
    slot_t slot_d [DEPTH];
    slot_t new_ent;

    logic                     hazard;
    logic [REG_AW-1:0]        src_k;
    logic [NUM_SRC*SEL_W-1:0] fwd_sel_c;
    logic [CNT_W-1:0]         cnt_c;
    logic [2**REG_AW-1:0]     pend_c;

    // Hazard detection and forwarding select. Slots are scanned oldest to
    // youngest so the youngest match overwrites and wins.
    always_comb begin
        hazard    = 1'b0;
        fwd_sel_c = '0;
        src_k     = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            src_k = issue_src_i[k*REG_AW +: REG_AW];
            for (int s = DEPTH - 1; s >= 0; s--) begin
                if (issue_src_used_i[k] && slot_q[s].vld && slot_q[s].we &&
                    slot_q[s].rd == src_k && src_k != '0) begin
                    if (FWD_EN != 0) begin
                        fwd_sel_c[k*SEL_W +: SEL_W] = SEL_W'(s + 1);
                        // A load in EX has no result on any bypass yet.
                        if (s == 0 && slot_q[s].ld) begin
                            hazard = 1'b1;
                        end
                    end else if (s < DEPTH - 1) begin
                        // The last slot writes a write-through regfile this
                        // cycle, so only the older-than-last slots block.
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

    // Slot contents clear on reset, so these read zero while rst_ni is low.
    always_comb begin
        cnt_c  = '0;
        pend_c = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if (slot_q[s].vld && slot_q[s].we && slot_q[s].rd != '0) begin
                cnt_c                = cnt_c + CNT_W'(1);
                pend_c[slot_q[s].rd] = 1'b1;
            end
        end
    end

    assign stall_o        = rst_ni & issue_valid_i & (hazard | hold_i);
    assign issue_accept_o = rst_ni & issue_valid_i & ~stall_o & ~flush_i;
    assign fwd_sel_o      = fwd_sel_c;
    assign inflight_cnt_o = cnt_c;
    assign pending_o      = pend_c;

    // Writes to x0 are stored as non-writing so they occupy a slot but
    // never match and are never counted.
    always_comb begin
        new_ent.vld = 1'b1;
        new_ent.rd  = issue_rd_i;
        new_ent.we  = issue_we_i & (issue_rd_i != '0);
        new_ent.ld  = issue_is_load_i;
    end

    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            slot_d[s] = slot_q[s];
        end
        if (!hold_i) begin
            for (int s = DEPTH - 1; s >= 1; s--) begin
                slot_d[s] = slot_q[s - 1];
                // Flush kills the instruction leaving EX.
                if (s == 1 && flush_i) begin
                    slot_d[s].vld = 1'b0;
                end
            end
            // issue_accept_o is already low under flush, so slot 0 bubbles.
            slot_d[0] = issue_accept_o ? new_ent : slot_t'('0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < DEPTH; s++) begin
                slot_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < DEPTH; s++) begin
                slot_q[s] <= slot_d[s];
            end
        end
    end

endmodule

// File: tb/tb_pipe_scoreboard.sv
`timescale 1ns/1ps
module tb_pipe_scoreboard;

    localparam int AW = 5;
    localparam int D  = 3;
    localparam int NS = 2;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic iv, we, ld, hold, flush;
    logic [NS*AW-1:0] src;
    logic [NS-1:0]    used;
    logic [AW-1:0]    rd;

    logic             a_stall, a_acc, n_stall, n_acc;
    logic [NS*SW-1:0] a_fwd, n_fwd;
    logic [SW-1:0]    a_cnt, n_cnt;
    logic [31:0]      a_pend, n_pend;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_scoreboard #(.REG_AW(AW), .DEPTH(D), .NUM_SRC(NS), .FWD_EN(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(iv), .issue_src_i(src),
        .issue_src_used_i(used), .issue_rd_i(rd), .issue_we_i(we),
        .issue_is_load_i(ld), .hold_i(hold), .flush_i(flush),
        .stall_o(a_stall), .issue_accept_o(a_acc), .fwd_sel_o(a_fwd),
        .inflight_cnt_o(a_cnt), .pending_o(a_pend));

    pipe_scoreboard #(.REG_AW(AW), .DEPTH(D), .NUM_SRC(NS), .FWD_EN(0)) u_n (
        .clk_i(clk), .rst_ni(rst_n), .issue_valid_i(iv), .issue_src_i(src),
        .issue_src_used_i(used), .issue_rd_i(rd), .issue_we_i(we),
        .issue_is_load_i(ld), .hold_i(hold), .flush_i(flush),
        .stall_o(n_stall), .issue_accept_o(n_acc), .fwd_sel_o(n_fwd),
        .inflight_cnt_o(n_cnt), .pending_o(n_pend));

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(hold && flush)) else $error("FAIL hold_flush_exclusive: both high");
        end
    end

    // ---------------- reference model ----------------
    // Each model keeps only the accepted writing instructions, tagged with
    // their age in pipeline steps since acceptance.
    typedef struct {
        int rd;
        bit ld;
        int age;
    } ent_t;

    ent_t q0[$];   // forwarding variant
    ent_t q1[$];   // no-forwarding variant

    function automatic void eval(input int m, output bit st, output bit ac,
                                 output int sel0, output int sel1,
                                 output int cnt, output logic [31:0] pend);
        ent_t q[$];
        int   s[2];
        int   best[2];
        bit   haz;
        bit   fe;
        fe  = (m == 0);
        haz = 1'b0;
        if (m == 0) q = q0; else q = q1;
        s[0] = int'(src[AW-1:0]);
        s[1] = int'(src[2*AW-1:AW]);
        for (int k = 0; k < 2; k++) begin
            best[k] = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (used[k] && s[k] != 0 && q[i].rd == s[k]) begin
                    if (best[k] < 0 || q[i].age < best[k]) best[k] = q[i].age;
                    if (fe ? (q[i].age == 0 && q[i].ld) : (q[i].age < D - 1)) haz = 1'b1;
                end
            end
        end
        sel0 = (fe && best[0] >= 0) ? best[0] + 1 : 0;
        sel1 = (fe && best[1] >= 0) ? best[1] + 1 : 0;
        cnt  = q.size();
        pend = '0;
        for (int i = 0; i < q.size(); i++) pend[q[i].rd] = 1'b1;
        st = rst_n && iv && (haz || hold);
        ac = rst_n && iv && !st && !flush;
    endfunction

    function automatic void upd(input int m);
        ent_t q[$];
        ent_t nq[$];
        ent_t e;
        bit st, ac;
        int x0, x1, c;
        logic [31:0] p;
        eval(m, st, ac, x0, x1, c, p);
        if (m == 0) q = q0; else q = q1;
        nq = {};
        if (!rst_n) begin
            nq = {};
        end else if (hold) begin
            nq = q;
        end else begin
            for (int i = 0; i < q.size(); i++) begin
                if (!(flush && q[i].age == 0) && q[i].age + 1 < D) begin
                    e = q[i];
                    e.age = e.age + 1;
                    nq.push_back(e);
                end
            end
            if (ac && we && rd != 0) begin
                e.rd = int'(rd); e.ld = ld; e.age = 0;
                nq.push_back(e);
            end
        end
        if (m == 0) q0 = nq; else q1 = nq;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic check_a(input string nm, input int st, input int ac, input int f0,
                           input int f1, input int cnt, input logic [31:0] pend);
        chk({nm, ".stall"},  32'(a_stall),      32'(st));
        chk({nm, ".accept"}, 32'(a_acc),        32'(ac));
        chk({nm, ".fwd0"},   32'(a_fwd[1:0]),   32'(f0));
        chk({nm, ".fwd1"},   32'(a_fwd[3:2]),   32'(f1));
        chk({nm, ".cnt"},    32'(a_cnt),        32'(cnt));
        chk({nm, ".pend"},   a_pend,            pend);
    endtask

    task automatic rcheck(input string nm);
        bit st, ac;
        int s0, s1, c;
        logic [31:0] p;
        eval(0, st, ac, s0, s1, c, p);
        check_a({nm, "_fwd"}, int'(st), int'(ac), s0, s1, c, p);
        eval(1, st, ac, s0, s1, c, p);
        chk({nm, "_nf.stall"},  32'(n_stall),    32'(st));
        chk({nm, "_nf.accept"}, 32'(n_acc),      32'(ac));
        chk({nm, "_nf.fwd0"},   32'(n_fwd[1:0]), 32'(s0));
        chk({nm, "_nf.fwd1"},   32'(n_fwd[3:2]), 32'(s1));
        chk({nm, "_nf.cnt"},    32'(n_cnt),      32'(c));
        chk({nm, "_nf.pend"},   n_pend,          p);
    endtask

    task automatic tick();
        @(posedge clk);
        upd(0);
        upd(1);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input int s0, input int s1, input logic [1:0] u,
                         input int r, input logic w, input logic l);
        iv = v; src = {AW'(s1), AW'(s0)}; used = u; rd = AW'(r); we = w; ld = l;
    endtask

    typedef struct {
        logic v; int s0; int s1; logic [1:0] u; int r; logic w; logic l;
        int st; int ac; int f0; int f1; int cnt; logic [31:0] pend;
    } vec_t;

    function automatic vec_t mk(input logic v, input int s0, input int s1, input logic [1:0] u,
                                input int r, input logic w, input logic l,
                                input int st, input int ac, input int f0, input int f1,
                                input int cnt, input logic [31:0] pend);
        vec_t t;
        t.v = v; t.s0 = s0; t.s1 = s1; t.u = u; t.r = r; t.w = w; t.l = l;
        t.st = st; t.ac = ac; t.f0 = f0; t.f1 = f1; t.cnt = cnt; t.pend = pend;
        return t;
    endfunction

    function automatic logic [31:0] b(input int r);
        logic [31:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        // back-to-back ALU RAW, then drain
        tbl.push_back(mk(1, 0, 0, 2'b00, 5, 1, 0,  0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0,  0, 1, 1, 0, 1, b(5)));
        tbl.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0,  0, 1, 2, 0, 1, b(5)));
        tbl.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0,  0, 1, 3, 0, 1, b(5)));
        tbl.push_back(mk(1, 5, 0, 2'b01, 0, 0, 0,  0, 1, 0, 0, 0, 32'h0));
        // load-use: one stall, then forward from slot 1
        tbl.push_back(mk(1, 0, 0, 2'b00, 7, 1, 1,  0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 7, 2'b10, 8, 0, 0,  1, 0, 0, 1, 1, b(7)));
        tbl.push_back(mk(1, 0, 7, 2'b10, 8, 0, 0,  0, 1, 0, 2, 1, b(7)));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 1, b(7)));
        // x0 destination/source and unused source
        tbl.push_back(mk(1, 0, 0, 2'b00, 0, 1, 0,  0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 2'b01, 9, 1, 0,  0, 1, 0, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 9, 2'b01, 0, 0, 0,  0, 1, 0, 0, 1, b(9)));
        // youngest-wins: rd=3 in slots 0 and 2
        tbl.push_back(mk(1, 0, 0, 2'b00, 3, 1, 0,  0, 1, 0, 0, 1, b(9)));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 2, b(3) | b(9)));
        tbl.push_back(mk(1, 0, 0, 2'b00, 3, 1, 0,  0, 1, 0, 0, 1, b(3)));
        tbl.push_back(mk(1, 3, 3, 2'b11, 0, 0, 0,  0, 1, 1, 1, 2, b(3)));
        tbl.push_back(mk(0, 3, 0, 2'b01, 0, 0, 0,  0, 0, 2, 0, 1, b(3)));
        tbl.push_back(mk(0, 0, 0, 2'b00, 0, 0, 0,  0, 0, 0, 0, 1, b(3)));

        // reset state, with hold and issue_valid high to show stall is gated
        drive(1, 0, 0, 2'b00, 0, 0, 0);
        hold = 1'b1; flush = 1'b0;
        #12;
        check_a("reset_a", 0, 0, 0, 0, 0, 32'h0);
        chk("reset_nf.stall", 32'(n_stall), 32'h0);
        chk("reset_nf.cnt",   32'(n_cnt),   32'h0);
        hold = 1'b0; iv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].u, tbl[i].r, tbl[i].w, tbl[i].l);
            #2;
            check_a($sformatf("vec%0d", i), tbl[i].st, tbl[i].ac, tbl[i].f0, tbl[i].f1,
                    tbl[i].cnt, tbl[i].pend);
            tick();
        end

        // flush kills slot 0 load and the concurrent issue
        drive(1, 0, 0, 2'b00, 4, 1, 1);
        #2; chk("flush_ld.accept", 32'(a_acc), 32'h1);
        tick();
        drive(1, 4, 0, 2'b01, 0, 0, 0); flush = 1'b1;
        #2; chk("flush.accept", 32'(a_acc), 32'h0);
        chk("flush.fwd0", 32'(a_fwd[1:0]), 32'h1);
        tick();
        flush = 1'b0;
        #2; check_a("post_flush", 0, 1, 0, 0, 0, 32'h0);
        tick();

        // hold freezes slots; async reset mid-hold
        drive(1, 0, 0, 2'b00, 10, 1, 0);
        #2; chk("pre_hold.accept", 32'(a_acc), 32'h1);
        tick();
        drive(1, 10, 0, 2'b01, 0, 0, 0); hold = 1'b1;
        for (int h = 0; h < 4; h++) begin
            #2; check_a($sformatf("hold%0d", h), 1, 0, 1, 0, 1, b(10));
            if (h < 3) tick();
        end
        #1; rst_n = 1'b0;
        #1; check_a("hold_rst", 0, 0, 0, 0, 0, 32'h0);
        tick();
        hold = 1'b0; rst_n = 1'b1;
        drive(1, 0, 0, 2'b00, 11, 1, 0);
        #2; check_a("after_rst", 0, 1, 0, 0, 0, 32'h0);
        tick();
        drive(0, 0, 0, 2'b00, 0, 0, 0);
        #2; chk("after_rst.cnt", 32'(a_cnt), 32'h1);
        chk("after_rst.pend", a_pend, b(11));

        // no-forwarding variant: stall DEPTH-1 cycles
        rst_n = 1'b0; q0.delete(); q1.delete();
        #1; rst_n = 1'b1;
        tick();
        drive(1, 0, 0, 2'b00, 6, 1, 0);
        #2; chk("nf_issue.accept", 32'(n_acc), 32'h1);
        tick();
        drive(1, 6, 0, 2'b01, 0, 0, 0);
        #2; chk("nf_c1.stall", 32'(n_stall), 32'h1);
        chk("nf_c1.accept", 32'(n_acc), 32'h0);
        chk("fw_c1.stall", 32'(a_stall), 32'h0);
        chk("fw_c1.fwd0", 32'(a_fwd[1:0]), 32'h1);
        tick();
        #2; chk("nf_c2.stall", 32'(n_stall), 32'h1);
        tick();
        #2; chk("nf_c3.stall", 32'(n_stall), 32'h0);
        chk("nf_c3.accept", 32'(n_acc), 32'h1);
        chk("nf_c3.fwd0", 32'(n_fwd[1:0]), 32'h0);
        tick();

        // randomized against the reference model
        rst_n = 1'b0; q0.delete(); q1.delete();
        #1; rst_n = 1'b1;
        tick();
        for (int i = 0; i < 600; i++) begin
            int r;
            if (i == 300) begin
                rst_n = 1'b0; q0.delete(); q1.delete();
                #1; rcheck("rnd_rst");
                rst_n = 1'b1;
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  2'($urandom_range(0, 3)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0);
            r = $urandom_range(0, 7);
            hold  = (r == 0);
            flush = (r == 1);
            #2; rcheck("rnd");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order integer pipeline.
- Tracks destination registers of instructions issued from decode until they leave writeback.
- Produces a decode stall for unresolvable RAW hazards and per-source forwarding selects.
- Generalises the fixed 5-stage hazard handling to a configurable pipeline depth, source count and forwarding mode, and adds flush and hold support.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero.
- DEPTH, 3, in-flight slots between issue and regfile write (slot 0 = EX … slot DEPTH-1 = WB); legal 1..8.
- NUM_SRC, 2, source operands checked per issue; legal 1..3.
- FWD_EN, 1, 1 = bypass network present; 0 = stall on any in-flight match.
- SEL_W, $clog2(DEPTH+1), width of each forwarding select.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode presents an instruction.
- issue_src  in  NUM_SRC*REG_AW  source addresses, src k at bits [k*REG_AW +: REG_AW].
- issue_src_used  in  NUM_SRC  per-source "operand read" flag.
- issue_rd  in  REG_AW  destination address.
- issue_we  in  1  instruction writes issue_rd.
- issue_is_load  in  1  result available only at slot 1 output (memory stage).
- hold  in  1  downstream stall (memory wait); freezes all slots.
- flush  in  1  branch redirect from EX; kills slot 0 and the current issue.
- stall  out  1  decode must hold; issue not accepted.
- issue_accept  out  1  issue_valid & ~stall & ~flush.
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 = regfile, s+1 = forward from slot s.
- inflight_cnt  out  $clog2(DEPTH+1)  number of valid writing slots.
- pending  out  2**REG_AW  bit r set if any valid slot writes r (bit 0 always 0).

Behaviour:
- Slot state: valid, rd, we, is_load per slot; all cleared on reset (rst low), asynchronously.
- While rst is low: stall=0, issue_accept=0, fwd_sel=0, inflight_cnt=0, pending=0.
- Match(k,s) = issue_src_used[k] & slot[s].valid & slot[s].we & slot[s].rd==src_k & src_k!=0.
- Forward select: youngest (lowest s) matching slot wins; fwd_sel[k] = s+1, else 0. Combinational, computed regardless of issue_valid.
- Hazard with FWD_EN=1: load-use only, i.e. any Match(k,0) where slot[0].is_load.
- Hazard with FWD_EN=0: any Match(k,s) for any s<DEPTH-1. Slot DEPTH-1 writes the regfile at the end of this cycle and the regfile is write-through, so it never stalls.
- stall = issue_valid & (hazard | hold). Flush does not assert stall.
- Every edge with hold=0:
  - slot[s+1] <= slot[s] for s<DEPTH-1; slot DEPTH-1 retires.
  - slot[0] <= issue entry if issue_accept, else a bubble (valid=0).
  - If flush: the entry shifting from slot 0 to slot 1 is invalidated and slot[0] becomes a bubble.
- Edge with hold=1:
  - All slots are unchanged.
  - flush is ignored. The controller guarantees flush and hold are never both high; the bench checks this with an assertion.
- issue_we=0 or issue_rd=0: the entry is stored with we=0; it occupies a slot but never matches and is not counted.
- inflight_cnt and pending are combinational from the registered slots (valid&we&rd!=0).
- Latency: accepted issue is visible in pending/fwd logic the cycle after acceptance; it leaves DEPTH cycles after acceptance, absent hold.
- Reset mid-operation: all in-flight entries are dropped immediately and outputs return to reset values. There is no replay.

Test Plan:
- Back-to-back ALU RAW (DEPTH=3, FWD_EN=1): issue rd=5, next cycle src0=5 -> stall=0, fwd_sel[0]=1. One cycle later -> fwd_sel=2. Then fwd_sel=3. Then 0.
- Load-use: issue load rd=7, next cycle src1=7 used -> stall=1 for exactly one cycle, then accept with fwd_sel[1]=2. inflight_cnt peaks at 1.
- x0 and unused sources: in-flight rd=0 and src0=0, plus in-flight rd=9 with src1=9 but issue_src_used[1]=0 -> stall=0, fwd_sel all 0, pending=0 for the rd=0 entry.
- Youngest-wins: slots 0 and 2 both write rd=3, issue src0=3 -> fwd_sel[0]=1.
- Flush: load rd=4 in slot 0, flush=1 with issue_valid src=4 -> issue_accept=0. Next cycle pending[4]=0, inflight_cnt=0, no stall.
- Hold plus async reset: hold=1 for 4 cycles -> slots frozen, stall=1 while issue_valid. Drop rst mid-hold -> outputs 0 immediately. After release, first issue is accepted.
- FWD_EN=0 variant: issue rd=6, then src0=6 -> stall for DEPTH-1=2 cycles, accept in the third cycle with fwd_sel=0.
